// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver and its byte FIFO.
// The PARITY state is only reachable when UART_RX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam int OSR_DEF    = 16;
    localparam int MID_SAMPLE = 7;
    localparam int FIFO_DEPTH = 4;
    localparam int DATA_W     = 8;
    localparam int PTR_W      = 2;
    localparam int CNT_W      = 3;

endpackage

// File: rtl/byte_fifo4.sv
// Four-entry byte FIFO with first-word fall-through head and a flattened
// snapshot of its live contents (oldest byte in the low lane).
module byte_fifo4
    import uart_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en_i,
    input  logic [DATA_W-1:0]            wr_data_i,
    input  logic                         rd_en_i,
    output logic [DATA_W-1:0]            rd_data_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic [CNT_W-1:0]             count_o,
    output logic [FIFO_DEPTH*DATA_W-1:0] buf_view_o
);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_wr;
    logic              do_rd;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
    assign count_o = count_q;

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a write alongside it.
    assign do_rd = rd_en_i && !empty_o;
    assign do_wr = wr_en_i && (!full_o || do_rd);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_wr);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_rd);
        count_d  = count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_view
            logic [PTR_W-1:0] slot;
            assign slot = rd_ptr_q + PTR_W'(gi);
            assign buf_view_o[gi*DATA_W +: DATA_W] =
                (CNT_W'(gi) < count_q) ? mem_q[slot] : '0;
        end
    endgenerate

endmodule

// File: rtl/uart_rx_fifo.sv
// 16x-oversampled UART receiver (8N1) feeding a 4-deep byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err pulse output.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115_200,
    parameter int OSR    = OSR_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rx,
    input  logic                         rd_en,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         empty,
    output logic                         full,
    output logic [CNT_W-1:0]             count,
    output logic                         byte_valid,
    output logic                         frame_err,
    output logic                         overrun,
`ifdef UART_RX_PARITY_EN
    output logic                         parity_err,
`endif
    output logic [FIFO_DEPTH*DATA_W-1:0] buf_view
);

    localparam int DIV    = CLK_HZ / (BAUD * OSR);
    localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SAMP_W = $clog2(OSR);
    localparam int BIDX_W = $clog2(DATA_W);

    rx_state_t           state_q, state_d;
    logic                rx_meta_q, rxs_q, rxs_prev_q;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [SAMP_W-1:0]   samp_q, samp_d;
    logic [BIDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic                byte_valid_q, byte_valid_d;
    logic                frame_err_q, frame_err_d;
    logic                overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic                parity_err_q, parity_err_d;
    logic                parity_bad_q, parity_bad_d;
`endif
    logic                tick;
    logic                mid;
    logic                start_edge;
    logic                fifo_wr;
    logic                fifo_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            rx_meta_q  <= rx;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
        end
    end

    assign tick       = (tick_cnt_q == TICK_W'(DIV - 1));
    assign mid        = tick && (samp_q == SAMP_W'(MID_SAMPLE));
    assign start_edge = (state_q == IDLE) && rxs_prev_q && !rxs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (start_edge) state_d = START;
            START:  if (mid) state_d = rxs_q ? IDLE : DATA;
            DATA: begin
                if (mid && (bit_idx_q == BIDX_W'(DATA_W - 1))) begin
`ifdef UART_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (mid) state_d = STOP;
`endif
            STOP:   if (mid) state_d = rxs_q ? IDLE : BREAK;
            BREAK:  if (rxs_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tick_cnt_d   = tick ? '0 : tick_cnt_q + TICK_W'(1);
        samp_d       = samp_q;
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        fifo_wr      = 1'b0;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_d = 1'b0;
        parity_bad_d = parity_bad_q;
`endif
        if (tick) begin
            samp_d = (samp_q == SAMP_W'(OSR - 1)) ? '0 : samp_q + SAMP_W'(1);
        end
        // Restarting both counters on the edge centres later samples in each bit.
        if (start_edge) begin
            tick_cnt_d = '0;
            samp_d     = '0;
        end
        unique case (state_q)
            START: if (mid) bit_idx_d = '0;
            DATA: begin
                if (mid) begin
                    shreg_d   = {rxs_q, shreg_q[DATA_W-1:1]};
                    bit_idx_d = bit_idx_q + BIDX_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (mid) parity_bad_d = rxs_q ^ (^shreg_q);
`endif
            STOP: begin
                if (mid) begin
                    if (!rxs_q) begin
                        frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (parity_bad_q) begin
                        parity_err_d = 1'b1;
`endif
                    end else if (fifo_full && !rd_en) begin
                        overrun_d = 1'b1;
                    end else begin
                        fifo_wr      = 1'b1;
                        byte_valid_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q   <= '0;
            samp_q       <= '0;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
            parity_bad_q <= 1'b0;
`endif
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            samp_q       <= samp_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
            parity_bad_q <= parity_bad_d;
`endif
        end
    end

    assign byte_valid = byte_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif
    assign full       = fifo_full;

    byte_fifo4 u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (fifo_wr),
        .wr_data_i  (shreg_q),
        .rd_en_i    (rd_en),
        .rd_data_o  (rd_data),
        .empty_o    (empty),
        .full_o     (fifo_full),
        .count_o    (count),
        .buf_view_o (buf_view)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: table-driven frames, corner-case sequences,
// then random frames scored against a queue model. Honours UART_RX_PARITY_EN.
module tb_uart_rx_fifo;

    localparam int BAUD   = 115_200;
    localparam int OSR    = 16;
    localparam int DIV    = 4;
    localparam int CLK_HZ = BAUD * OSR * DIV;
    localparam int BIT    = OSR * DIV;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS  = 11;
`else
    localparam int NBITS  = 10;
`endif
    localparam int FRAME  = NBITS * BIT;
    // Negedge index (from the start-bit drive) of the cycle whose closing edge registers the stop decision:
    // 2 sync flops + edge flop, then mid of the stop bit = OSR/2 + OSR*(NBITS-1) ticks.
    localparam int WR_CLK = 2 + (OSR / 2 + OSR * (NBITS - 1)) * DIV;

    logic        clk = 1'b0;
    logic        rst_n, rx, rd_en;
    logic [7:0]  rd_data;
    logic        empty, full, byte_valid, frame_err, overrun;
    logic [2:0]  count;
    logic [31:0] buf_view;
`ifdef UART_RX_PARITY_EN
    logic        parity_err;
    logic        bad_par_g = 1'b0;
    int          pe_tot = 0;
`endif

    uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OSR(OSR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .byte_valid (byte_valid),
        .frame_err  (frame_err),
        .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .buf_view   (buf_view)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int bv_tot = 0, fe_tot = 0, ov_tot = 0;
    int min_cnt;
    bit track_min = 1'b0;
    logic [7:0] model_q[$];

    always @(negedge clk) begin
        if (byte_valid) bv_tot <= bv_tot + 1;
        if (frame_err)  fe_tot <= fe_tot + 1;
        if (overrun)    ov_tot <= ov_tot + 1;
`ifdef UART_RX_PARITY_EN
        if (parity_err) pe_tot <= pe_tot + 1;
`endif
    end

    typedef struct packed {
        logic [7:0]  data;
        logic        stop;
        logic [1:0]  pops;
        logic [2:0]  cnt;
        logic [7:0]  rd;
        logic [31:0] view;
        logic        bv;
        logic        fe;
        logic        ov;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drives one frame at negedges; pops occur early in the frame, rd_at adds one pop at that index.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int npops, input int rd_at);
        logic [NBITS-1:0] bits;
        bits = '1;
        bits[0]   = 1'b0;
        bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
        bits[9]   = (^d) ^ bad_par_g;
`endif
        bits[NBITS-1] = stop_bit;
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            if (track_min && int'(count) < min_cnt) min_cnt = int'(count);
            rx    = bits[c / BIT];
            rd_en = (c == rd_at) || (c >= 10 && c < 10 + 2 * npops && ((c - 10) % 2 == 0));
        end
        $display("frame data=%h stop=%b pops=%0d rd_at=%0d -> count=%0d rd_data=%h buf_view=%h",
                 d, stop_bit, npops, rd_at, count, rd_data, buf_view);
    endtask

    task automatic idle_bits(input int n);
        for (int c = 0; c < n * BIT; c++) begin
            @(negedge clk);
            rx    = 1'b1;
            rd_en = 1'b0;
        end
    endtask

    function automatic logic [31:0] model_view();
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < model_q.size(); k++) v[8*k +: 8] = model_q[k];
        return v;
    endfunction

    initial begin
        int bv0, fe0, ov0;
        logic [7:0] d;
        logic stop;
        int npops, rd_at, gap, exp_bv, exp_fe, exp_ov;

        vecs[0] = '{8'hA5, 1'b1, 2'd0, 3'd1, 8'hA5, 32'h000000A5, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 2'd1, 3'd0, 8'h00, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h11, 1'b1, 2'd0, 3'd1, 8'h11, 32'h00000011, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h01, 1'b1, 2'd1, 3'd1, 8'h01, 32'h00000001, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h02, 1'b1, 2'd0, 3'd2, 8'h01, 32'h00000201, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h03, 1'b1, 2'd0, 3'd3, 8'h01, 32'h00030201, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h04, 1'b1, 2'd0, 3'd4, 8'h01, 32'h04030201, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'h05, 1'b1, 2'd0, 3'd4, 8'h01, 32'h04030201, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{8'h06, 1'b1, 2'd2, 3'd3, 8'h03, 32'h00060403, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{8'h07, 1'b1, 2'd0, 3'd4, 8'h03, 32'h07060403, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0;
        rx    = 1'b1;
        rd_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_buf_view", buf_view, 32'd0);
        check("rst_pulses", {29'd0, byte_valid, frame_err, overrun}, 32'd0);
        rst_n = 1'b1;
        idle_bits(1);

        for (int i = 0; i < 10; i++) begin
            bv0 = bv_tot; fe0 = fe_tot; ov0 = ov_tot;
            send_frame(vecs[i].data, vecs[i].stop, int'(vecs[i].pops), -1);
            check($sformatf("tbl%0d_count", i), 32'(count), 32'(vecs[i].cnt));
            check($sformatf("tbl%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].rd));
            check($sformatf("tbl%0d_buf_view", i), buf_view, vecs[i].view);
            check($sformatf("tbl%0d_byte_valid", i), 32'(bv_tot - bv0), 32'(vecs[i].bv));
            check($sformatf("tbl%0d_frame_err", i), 32'(fe_tot - fe0), 32'(vecs[i].fe));
            check($sformatf("tbl%0d_overrun", i), 32'(ov_tot - ov0), 32'(vecs[i].ov));
            idle_bits(1);
        end
        check("tbl_full_flag", 32'(full), 32'd1);

        // Glitch shorter than half a bit must be rejected silently.
        bv0 = bv_tot; fe0 = fe_tot; ov0 = ov_tot;
        for (int c = 0; c < 5 * DIV; c++) begin
            @(negedge clk);
            rx = 1'b0;
        end
        idle_bits(2);
        $display("glitch 5 ticks -> count=%0d buf_view=%h", count, buf_view);
        check("glitch_pulses", 32'((bv_tot - bv0) + (fe_tot - fe0) + (ov_tot - ov0)), 32'd0);
        check("glitch_buf_view", buf_view, 32'h07060403);

        // Pop in exactly the stop-bit write cycle of a full FIFO.
        bv0 = bv_tot; ov0 = ov_tot;
        min_cnt = 99;
        track_min = 1'b1;
        send_frame(8'h99, 1'b1, 0, WR_CLK);
        track_min = 1'b0;
        check("simul_min_count", 32'(min_cnt), 32'd4);
        check("simul_count", 32'(count), 32'd4);
        check("simul_overrun", 32'(ov_tot - ov0), 32'd0);
        check("simul_byte_valid", 32'(bv_tot - bv0), 32'd1);
        check("simul_buf_view", buf_view, 32'h99070604);
        check("simul_rd_data", 32'(rd_data), 32'h04);
        idle_bits(1);

        // Reset during bit 4 of 0xF0 (line held at bit value until reset).
        for (int c = 0; c < 5 * BIT + BIT / 2; c++) begin
            @(negedge clk);
            rx = (c < BIT) ? 1'b0 : ((c < 5 * BIT) ? 1'b0 : 1'b1);
        end
        rst_n = 1'b0;
        rx    = 1'b1;
        #1;
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_buf_view", buf_view, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_bits(1);
        bv0 = bv_tot; fe0 = fe_tot;
        send_frame(8'h5A, 1'b1, 0, -1);
        check("midrst_after_count", 32'(count), 32'd1);
        check("midrst_after_rd", 32'(rd_data), 32'h5A);
        check("midrst_after_bv", 32'(bv_tot - bv0), 32'd1);
        check("midrst_after_fe", 32'(fe_tot - fe0), 32'd0);
        idle_bits(1);

`ifdef UART_RX_PARITY_EN
        begin
            int pe0;
            bv0 = bv_tot; pe0 = pe_tot;
            bad_par_g = 1'b1;
            send_frame(8'h07, 1'b1, 0, -1);
            bad_par_g = 1'b0;
            check("par_err_pulse", 32'(pe_tot - pe0), 32'd1);
            check("par_no_write", 32'(bv_tot - bv0), 32'd0);
            check("par_count", 32'(count), 32'd1);
            idle_bits(1);
        end
`endif

        model_q = {};
        model_q.push_back(8'h5A);
        for (int i = 0; i < 30; i++) begin
            d      = 8'($urandom_range(0, 255));
            stop   = ($urandom_range(0, 7) != 0);
            npops  = $urandom_range(0, 2);
            rd_at  = ($urandom_range(0, 3) == 0) ? WR_CLK : -1;
            gap    = stop ? $urandom_range(0, 1) : 1;
            exp_bv = 0; exp_fe = 0; exp_ov = 0;
            for (int p = 0; p < npops + ((rd_at >= 0) ? 1 : 0); p++) begin
                if (model_q.size() > 0) void'(model_q.pop_front());
            end
            if (!stop) exp_fe = 1;
            else if (model_q.size() == 4) exp_ov = 1;
            else begin
                model_q.push_back(d);
                exp_bv = 1;
            end
            bv0 = bv_tot; fe0 = fe_tot; ov0 = ov_tot;
            send_frame(d, stop, npops, rd_at);
            check($sformatf("rnd%0d_count", i), 32'(count), 32'(model_q.size()));
            check($sformatf("rnd%0d_rd_data", i), 32'(rd_data),
                  (model_q.size() > 0) ? 32'(model_q[0]) : 32'd0);
            check($sformatf("rnd%0d_buf_view", i), buf_view, model_view());
            check($sformatf("rnd%0d_flags", i), {30'd0, empty, full},
                  {30'd0, model_q.size() == 0, model_q.size() == 4});
            check($sformatf("rnd%0d_pulses", i),
                  32'((bv_tot - bv0) * 100 + (fe_tot - fe0) * 10 + (ov_tot - ov0)),
                  32'(exp_bv * 100 + exp_fe * 10 + exp_ov));
            if (gap > 0) idle_bits(gap);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- 16x-oversampled UART receiver with a 4-deep byte FIFO. Sits downstream of the transmitter on the TX/RX serial line.
- Supplies received bytes to consumers: the display path via a flat 4-byte snapshot, and a pop interface for future logic.
- Runs on the 100 MHz system clock. Generates its own sample tick internally, so no separate baud clock domain is needed.

Parameters:
- CLK_HZ, 100_000_000: system clock frequency.
- BAUD, 115_200: line rate.
- OSR, 16: samples per bit.
- DIV, CLK_HZ/(BAUD*OSR) truncated (54): clocks per sample tick. Derived; do not override.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx  in  1  serial line, asynchronous to clk; idle high.
- rd_en  in  1  pop the head byte; ignored when empty.
- rd_data  out  8  head byte (first-word fall-through); 0x00 when empty.
- empty  out  1  FIFO holds no bytes.
- full  out  1  FIFO holds 4 bytes.
- count  out  3  occupancy, 0..4.
- byte_valid  out  1  one-clk pulse when a good byte is written.
- frame_err  out  1  one-clk pulse when the stop bit is sampled as 0.
- overrun  out  1  one-clk pulse when a good byte is dropped because the FIFO is full.
- buf_view  out  32  FIFO contents; [7:0] = oldest. Unused slots read 0x00.

Behaviour:
- Reset values: rx synchronizer flops = 1; state = IDLE; all counters = 0; empty = 1; full = 0; count = 0; rd_data = 0; buf_view = 0; all pulse outputs = 0.
- rx passes through a 2-flop synchronizer. All decisions use the synchronized value rxs.
- Tick counter:
  - Counts 0..DIV-1 and asserts tick on wrap.
  - Free-running in IDLE.
  - Cleared to 0 on start-edge detection, so sampling phase aligns to the edge.
- Sample counter: 4 bits, counts ticks within a bit. The mid-bit sample is taken at sample count 7.
- IDLE: rxs falling edge (previous 1, current 0) -> START; clear tick and sample counters.
- START: at mid-bit:
  - rxs == 0 -> DATA with bit index 0.
  - rxs == 1 -> IDLE (glitch rejected; no pulses).
- DATA:
  - Sample every 16 ticks at mid-bit and shift in LSB first.
  - After bit index 7 -> STOP (or PARITY when the optional feature is enabled).
- STOP: at mid-bit:
  - rxs == 1, FIFO not full (or rd_en this cycle) -> write byte, pulse byte_valid, go IDLE.
  - rxs == 1, FIFO full and no rd_en -> drop byte, pulse overrun, go IDLE.
  - rxs == 0 -> drop byte, pulse frame_err, go BREAK.
- BREAK: wait for rxs == 1, then -> IDLE. This prevents a held-low line from producing repeated frames.
- FIFO:
  - 4 entries with 2-bit read/write pointers that wrap 3 -> 0.
  - A write in the same clk as a read when full: both succeed; count stays 4.
  - A read in the same clk as a write when empty: only the write happens; count becomes 1.
  - rd_en while empty: no effect.
- Latency: byte_valid, the write, and the count/empty/full/rd_data/buf_view updates all appear together. They are registered on the clk after the stop-bit mid sample.
- Reset asserted mid-frame: everything returns to reset values immediately. The partial byte and the FIFO contents are discarded.
- A frame arriving back-to-back with no idle time after the stop bit is received correctly, because the stop sample occurs at mid-bit.

Optional Feature:
- UART_RX_PARITY_EN defined:
  - Adds a PARITY state between DATA and STOP that samples one even-parity bit.
  - Adds output parity_err (1 bit, one-clk pulse, reset 0).
  - Parity mismatch at STOP: byte is dropped and parity_err pulses instead of byte_valid; frame_err still takes priority.
- Not defined: 8N1 framing; the parity_err port and PARITY state do not exist.

Decomposition:
- Package uart_pkg: rx_state_t enum (IDLE, START, DATA, PARITY, STOP, BREAK), OSR_DEF, MID_SAMPLE = 7, FIFO_DEPTH = 4, and a DATA_W = 8 localparam.
- One sub-module, byte_fifo4: pointers, count, full/empty, first-word fall-through rd_data, and buf_view flattening.
- The receive state machine stays in uart_rx_fifo.

Test Plan:
- Single byte: send 0xA5 at 115200 8N1 -> one byte_valid pulse; rd_data = 0xA5; count = 1; buf_view = 0x000000A5.
- Glitch: rx low for 5 ticks (< mid-bit), then high -> FSM returns to IDLE; no pulses; count = 0.
- Framing error: send 0x3C with stop bit = 0, then idle high -> frame_err pulses once; count = 0; the next byte 0x11 is received normally.
- Overrun and wrap: send 0x01..0x05 with no reads -> full after 0x04; overrun pulses on 0x05; buf_view = 0x04030201. Then pop twice, send 0x06 and 0x07 -> buf_view = 0x07060403 (pointer wrap exercised).
- Simultaneous events: FIFO full, rd_en asserted in the stop-bit write cycle of 0x99 -> no overrun; count stays 4; oldest byte removed; 0x99 is at the tail.
- Reset mid-frame: assert rst_n = 0 during bit 4 of 0xF0, release, send 0x5A -> only 0x5A is received; count = 1. With UART_RX_PARITY_EN: 0x07 with a wrong parity bit -> parity_err pulse and no write.
